// File: rtl/inference_pkg.sv
// Shared definitions for the inference result table: widths, entry layout,
// hash constants, op codes and writer FSM states.
package inference_pkg;

  localparam int DEF_KEY_WIDTH   = 104;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_CLASS_WIDTH = 4;

  localparam int ENTRY_VALID_BIT = 0;
  localparam int ENTRY_CLASS_LSB = 1;
  localparam int ENTRY_CLASS_MSB = DEF_CLASS_WIDTH;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic OP_INSTALL = 1'b0;
  localparam logic OP_DELETE  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HASH  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CLEAR = 2'd3
  } wr_state_e;

endpackage

// File: rtl/tfe_crc16_hash.sv
// Combinational CRC-16 (poly 0x1021, init 0xFFFF, MSB first, no reflection,
// no final XOR) of a flow key; shared with the lookup path.
module tfe_crc16_hash
  import inference_pkg::*;
#(
  parameter int KEY_WIDTH = DEF_KEY_WIDTH
) (
  input  logic [KEY_WIDTH-1:0] key,
  output logic [15:0]          crc
);

  logic [15:0] crc_v;
  logic        fb;

  always_comb begin
    crc_v = CRC_INIT;
    fb    = 1'b0;
    for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
      fb    = crc_v[15] ^ key[i];
      crc_v = {crc_v[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    crc = crc_v;
  end

endmodule

// File: rtl/inference_result_writer.sv
// Write-side agent for the inference result table: hashes accepted results to
// a table index, issues single-cycle writes, and runs full-table clear sweeps.
module inference_result_writer
  import inference_pkg::*;
#(
  parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int CLASS_WIDTH = DEF_CLASS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [KEY_WIDTH-1:0]   res_key,
  input  logic [CLASS_WIDTH-1:0] res_class,
  input  logic                   res_op,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic                   wea,
  output logic [ADDR_WIDTH-1:0]  waddr,
  output logic [CLASS_WIDTH:0]   wdata,
  output logic [31:0]            wr_cnt
);

  wr_state_e              state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic                   op_q, op_d;
  logic [ADDR_WIDTH-1:0]  hash_q, hash_d;
  logic [ADDR_WIDTH-1:0]  sweep_q, sweep_d;
  logic                   pend_q, pend_d;
  logic                   done_q, done_d;
  logic [31:0]            wr_cnt_q, wr_cnt_d;
  logic [15:0]            crc_w;

  tfe_crc16_hash #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_hash (
    .key(key_q),
    .crc(crc_w)
  );

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    class_d   = class_q;
    op_d      = op_q;
    hash_d    = hash_q;
    sweep_d   = sweep_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    wr_cnt_d  = wr_cnt_q;
    res_ready = 1'b0;
    wea       = 1'b0;
    waddr     = '0;
    wdata     = '0;

    case (state_q)
      ST_IDLE: begin
        res_ready = !pend_q && !clr_start;
        // A requested clear always beats a waiting result.
        if (clr_start || pend_q) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end else if (res_valid) begin
          key_d   = res_key;
          class_d = res_class;
          op_d    = res_op;
          state_d = ST_HASH;
        end
      end
      ST_HASH: begin
        hash_d  = crc_w[ADDR_WIDTH-1:0];
        state_d = ST_WRITE;
        if (clr_start) pend_d = 1'b1;
      end
      ST_WRITE: begin
        wea      = 1'b1;
        waddr    = hash_q;
        wdata    = (op_q == OP_DELETE) ? '0 : {class_q, 1'b1};
        wr_cnt_d = wr_cnt_q + 32'd1;
        state_d  = ST_IDLE;
        if (clr_start) pend_d = 1'b1;
      end
      ST_CLEAR: begin
        wea     = 1'b1;
        waddr   = sweep_q;
        sweep_d = sweep_q + ADDR_WIDTH'(1);
        if (sweep_q == '1) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_busy = pend_q | (state_q == ST_CLEAR);
  assign clr_done = done_q;
  assign wr_cnt   = wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_cnt_q <= '0;
      sweep_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      wr_cnt_q <= wr_cnt_d;
      sweep_q  <= sweep_d;
    end
  end

  // Request payload and hash carry no reset; they are only consumed after
  // the FSM has moved through states that load them.
  always_ff @(posedge clk) begin
    key_q   <= key_d;
    class_q <= class_d;
    op_q    <= op_d;
    hash_q  <= hash_d;
  end

endmodule

// File: doc/inference_result_writer.md
Name: inference_result_writer

Overview:
- Write-side agent for the Inference Result Table; the packet-path query block reads that table and tags packets with the stored class.
- Accepts inference results from the inference engine as (five-tuple key, class, op) over a valid/ready handshake.
- Hashes the key to the table index and issues single-cycle write strobes (wea/waddr/wdata) on the table write port.
- Also provides a full-table clear sweep so stale classifications can be flushed.

Parameters:
KEY_WIDTH, 104, five-tuple width {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], proto[7:0]}, MSB first.
ADDR_WIDTH, 16, table index width; table depth 2^ADDR_WIDTH.
CLASS_WIDTH, 4, class label width; entry width CLASS_WIDTH+1.

Ports:
clk  in  1  block clock; the table write port is clocked by clk.
rst  in  1  synchronous, active-high reset.
res_valid  in  1  result request valid.
res_ready  out  1  result request accepted when high with res_valid.
res_key  in  KEY_WIDTH  five-tuple key.
res_class  in  CLASS_WIDTH  class label.
res_op  in  1  0 = install, 1 = delete (write invalid entry).
clr_start  in  1  one-cycle request to clear whole table.
clr_busy  out  1  high while the clear sweep runs or is pending.
clr_done  out  1  one-cycle pulse after the last clear write.
wea  out  1  table write enable, one cycle per write.
waddr  out  ADDR_WIDTH  table write address.
wdata  out  CLASS_WIDTH+1  entry {class, valid}; valid in bit 0.
wr_cnt  out  32  count of install/delete writes issued; wraps; clear-sweep writes not counted.

Behaviour:
- Reset: state IDLE, all outputs 0, clear pending flag 0. Reset mid-operation aborts any request or sweep; no further writes are issued.
- Hash: CRC-16, polynomial 0x1021, init 0xFFFF, no reflection, no final XOR, over res_key MSB first. waddr = crc[ADDR_WIDTH-1:0]. The hash must be bit-identical to the hash on the lookup side.
- FSM states IDLE, HASH, WRITE, CLEAR.
- IDLE:
  - res_ready = 1 iff no clear is pending and clr_start is 0.
  - clr_start or pending clear has priority: go to CLEAR with sweep counter 0.
  - Otherwise, on res_valid&res_ready: latch key, class, op; go to HASH.
- HASH: compute the CRC combinationally from the latched key, register it, go to WRITE.
- WRITE:
  - wea=1, waddr=hash, wdata = op ? 0 : {class, 1'b1}.
  - Increment wr_cnt; go to IDLE.
- Timing: acceptance in cycle N gives wea=1 in cycle N+2. Throughput is 1 request per 3 cycles. res_ready=0 outside IDLE.
- CLEAR:
  - wea=1 every cycle, waddr = sweep counter, wdata=0; counter increments.
  - When waddr = 2^ADDR_WIDTH-1: go to IDLE, clear pending flag, pulse clr_done in the following cycle.
  - Sweep takes exactly 2^ADDR_WIDTH cycles.
- clr_start in HASH/WRITE: set pending flag; the in-flight request completes first, then CLEAR is entered from IDLE.
- clr_start during CLEAR: ignored (no restart, no second clr_done).
- clr_busy = pending | (state==CLEAR).
- Entries written are never read back; duplicate keys overwrite; hash collisions overwrite silently (last writer wins).
- wea is 0 in IDLE and HASH.

Decomposition:
- Shared package inference_pkg:
  - KEY_WIDTH/ADDR_WIDTH/CLASS_WIDTH defaults.
  - Entry field positions (valid bit 0, class bits [CLASS_WIDTH:1]).
  - CRC polynomial 0x1021 and init 0xFFFF.
  - Op encodings OP_INSTALL=0, OP_DELETE=1.
  - FSM state encodings.
- One sub-module: tfe_crc16_hash, a purely combinational 104-bit CRC-16. The lookup path reuses it.

Test Plan:
- Install: key=0x0A000001_0A000002_1F90_0050_06, class=4'hA, op=0 -> wea=1 exactly 2 cycles after handshake, wdata=5'b10101, waddr equals golden CRC-16 model output, wr_cnt=1.
- Delete same key (op=1) -> same waddr, wdata=5'b00000, wr_cnt=2.
- Back-to-back res_valid held high with 4 distinct keys -> res_ready high only in IDLE, 4 writes spaced 3 cycles apart, addresses match model.
- clr_start asserted in the same cycle as res_valid in IDLE -> clear wins, res_ready=0. Exactly 65536 writes with waddr 0..65535 and wdata=0. clr_done pulses once. The held request is then accepted.
- clr_start during HASH -> pending request's write completes first, clr_busy=1 throughout, then full sweep. A second clr_start mid-sweep causes no extra clr_done.
- rst asserted mid-sweep at waddr=100 -> next cycle wea=0, clr_busy=0, wr_cnt=0, state IDLE, res_ready=1.
